// File: rtl/gray_decoder_tracker_pkg.sv
// Shared types and helpers for the gray decoder tracker.
// Holds the tracker state encoding and the gray-to-binary function.
package gray_decoder_tracker_pkg;

   localparam int unsigned MAX_N = 16;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_RESYNC = 2'd2
   } state_t;

   // Zero-extended input keeps the upper prefix XOR at 0,
   // so any narrower width can be converted by truncation.
   function automatic logic [MAX_N-1:0] gray2bin(
      input logic [MAX_N-1:0] g
   );
      logic [MAX_N-1:0] b;
      b[MAX_N-1] = g[MAX_N-1];
      for (int i = MAX_N - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_decoder_tracker_gray2bin.sv
// Combinational N-bit Gray to binary converter.
// Wraps the package conversion for an arbitrary width N.
module gray2bin_Nbits
   import gray_decoder_tracker_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   always_comb begin
      bin = N'(gray2bin(MAX_N'(gray)));
   end

endmodule

// File: rtl/gray_decoder_tracker.sv
// Two-stage Gray counter tracker: decode, step detection,
// multi-bit error detection with resync and error counting.
module gray_decoder_tracker
   import gray_decoder_tracker_pkg::*;
#(
   parameter int N    = 4,
   parameter int ERRW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clk_en,
   input  logic [N-1:0]    gray_in,
   input  logic            err_clr,
   output logic [N-1:0]    bin_out,
   output logic            bin_valid,
   output logic            step_up,
   output logic            step_down,
   output logic            err_multi,
   output logic            err_sticky,
   output logic [ERRW-1:0] err_cnt
);

   localparam logic [N-1:0]    ONE_N   = N'(1);
   localparam logic [ERRW-1:0] ONE_E   = ERRW'(1);
   localparam logic [ERRW-1:0] CNT_MAX = '1;

   state_t state_q, state_d;

   logic            s1_v_q, s1_v_d;
   logic [N-1:0]    s1_g_q, s1_g_d;
   logic [N-1:0]    prev_g_q, prev_g_d;
   logic [N-1:0]    bin_q, bin_d;
   logic            valid_q, valid_d;
   logic            up_q, up_d;
   logic            dn_q, dn_d;
   logic            em_q, em_d;
   logic            sticky_q, sticky_d;
   logic [ERRW-1:0] cnt_q, cnt_d;
   logic            match_q, match_d;

   logic [N-1:0] s1_bin;
   logic [N-1:0] diff;
   logic         same;
   logic         one_bit;
   logic         multi;
   logic         err_ev;

   gray2bin_Nbits #(
      .N(N)
   ) u_conv (
      .gray(s1_g_q),
      .bin (s1_bin)
   );

   always_comb begin
      diff    = s1_g_q ^ prev_g_q;
      same    = (diff == '0);
      one_bit = !same && ((diff & (diff - ONE_N)) == '0);
      multi   = !same && !one_bit;
      err_ev  = s1_v_q && (state_q == ST_TRACK) && multi;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_INIT;
         s1_v_q   <= 1'b0;
         s1_g_q   <= '0;
         prev_g_q <= '0;
         bin_q    <= '0;
         valid_q  <= 1'b0;
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
         em_q     <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         match_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         s1_v_q   <= s1_v_d;
         s1_g_q   <= s1_g_d;
         prev_g_q <= prev_g_d;
         bin_q    <= bin_d;
         valid_q  <= valid_d;
         up_q     <= up_d;
         dn_q     <= dn_d;
         em_q     <= em_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         match_q  <= match_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (s1_v_q) begin
         unique case (state_q)
            ST_INIT: state_d = ST_TRACK;
            ST_TRACK: begin
               if (multi) state_d = ST_RESYNC;
            end
            ST_RESYNC: begin
               if (same && match_q) state_d = ST_TRACK;
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   always_comb begin
      s1_v_d   = clk_en;
      s1_g_d   = clk_en ? gray_in : s1_g_q;
      prev_g_d = prev_g_q;
      bin_d    = bin_q;
      valid_d  = valid_q;
      up_d     = 1'b0;
      dn_d     = 1'b0;
      em_d     = 1'b0;
      match_d  = match_q;

      if (s1_v_q) begin
         unique case (state_q)
            ST_INIT: begin
               bin_d    = s1_bin;
               prev_g_d = s1_g_q;
               valid_d  = 1'b1;
               match_d  = 1'b0;
            end
            ST_TRACK: begin
               if (one_bit) begin
                  bin_d    = s1_bin;
                  prev_g_d = s1_g_q;
                  up_d     = (s1_bin == bin_q + ONE_N);
                  dn_d     = (s1_bin == bin_q - ONE_N);
               end else if (multi) begin
                  bin_d    = s1_bin;
                  prev_g_d = s1_g_q;
                  em_d     = 1'b1;
                  valid_d  = 1'b0;
                  match_d  = 1'b0;
               end
            end
            ST_RESYNC: begin
               if (same) begin
                  if (match_q) begin
                     valid_d = 1'b1;
                     match_d = 1'b0;
                  end else begin
                     match_d = 1'b1;
                  end
               end else begin
                  bin_d    = s1_bin;
                  prev_g_d = s1_g_q;
                  match_d  = 1'b0;
               end
            end
            default: begin
               valid_d = 1'b0;
               match_d = 1'b0;
            end
         endcase
      end
   end

   // Clear first so a coincident error lands on a fresh count.
   always_comb begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (err_clr) begin
         cnt_d    = '0;
         sticky_d = 1'b0;
      end
      if (err_ev) begin
         sticky_d = 1'b1;
         if (cnt_d != CNT_MAX) cnt_d = cnt_d + ONE_E;
      end
   end

   assign bin_out    = bin_q;
   assign bin_valid  = valid_q;
   assign step_up    = up_q;
   assign step_down  = dn_q;
   assign err_multi  = em_q;
   assign err_sticky = sticky_q;
   assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_gray_decoder_tracker.sv
// Directed bench for gray_decoder_tracker with N=4, ERRW=2.
// Expected values are hand-computed from the Gray code table.
module tb_gray_decoder_tracker;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_en;
   logic [3:0] gray_in;
   logic       err_clr;
   logic [3:0] bin_out;
   logic       bin_valid;
   logic       step_up;
   logic       step_down;
   logic       err_multi;
   logic       err_sticky;
   logic [1:0] err_cnt;

   int total = 0;
   int bad   = 0;

   gray_decoder_tracker #(
      .N   (4),
      .ERRW(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clk_en    (clk_en),
      .gray_in   (gray_in),
      .err_clr   (err_clr),
      .bin_out   (bin_out),
      .bin_valid (bin_valid),
      .step_up   (step_up),
      .step_down (step_down),
      .err_multi (err_multi),
      .err_sticky(err_sticky),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Sample enters stage 1 on the first edge, outputs settle
   // after the second; clr is applied on that second edge.
   task automatic smp(input logic [3:0] g, input logic clr);
      clk_en  = 1'b1;
      gray_in = g;
      @(posedge clk);
      #1;
      clk_en  = 1'b0;
      err_clr = clr;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
   endtask

   task automatic chk_pulses(input string tag, input logic u,
                             input logic d, input logic e);
      chk({tag, ".up"}, {31'd0, step_up}, {31'd0, u});
      chk({tag, ".dn"}, {31'd0, step_down}, {31'd0, d});
      chk({tag, ".em"}, {31'd0, err_multi}, {31'd0, e});
   endtask

   logic [3:0] walk [13];
   logic [1:0] exp_cnt;

   initial begin
      walk = '{4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
               4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
               4'b1011, 4'b1001, 4'b1000};
      rst     = 1'b1;
      clk_en  = 1'b0;
      gray_in = 4'd0;
      err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.bin", 32'(bin_out), 32'd0);
      chk("rst.valid", 32'(bin_valid), 32'd0);
      chk("rst.cnt", 32'(err_cnt), 32'd0);
      chk("rst.sticky", 32'(err_sticky), 32'd0);
      chk_pulses("rst", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      smp(4'b0000, 1'b0);
      chk("s0.bin", 32'(bin_out), 32'd0);
      chk("s0.valid", 32'(bin_valid), 32'd1);
      chk_pulses("s0", 1'b0, 1'b0, 1'b0);
      smp(4'b0001, 1'b0);
      chk("s1.bin", 32'(bin_out), 32'd1);
      chk_pulses("s1", 1'b1, 1'b0, 1'b0);
      smp(4'b0011, 1'b0);
      chk("s2.bin", 32'(bin_out), 32'd2);
      chk_pulses("s2", 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 13; i++) begin
         smp(walk[i], 1'b0);
         chk("walk.bin", 32'(bin_out), 32'(i + 3));
         chk("walk.up", 32'(step_up), 32'd1);
      end
      smp(4'b0000, 1'b0);
      chk("wrapup.bin", 32'(bin_out), 32'd0);
      chk_pulses("wrapup", 1'b1, 1'b0, 1'b0);
      smp(4'b1000, 1'b0);
      chk("wrapdn.bin", 32'(bin_out), 32'd15);
      chk_pulses("wrapdn", 1'b0, 1'b1, 1'b0);
      smp(4'b0000, 1'b0);
      chk("back0.bin", 32'(bin_out), 32'd0);
      chk_pulses("back0", 1'b1, 1'b0, 1'b0);

      smp(4'b0011, 1'b0);
      chk_pulses("err", 1'b0, 1'b0, 1'b1);
      chk("err.cnt", 32'(err_cnt), 32'd1);
      chk("err.sticky", 32'(err_sticky), 32'd1);
      chk("err.valid", 32'(bin_valid), 32'd0);
      chk("err.bin", 32'(bin_out), 32'd2);
      smp(4'b0011, 1'b0);
      chk("rs1.valid", 32'(bin_valid), 32'd0);
      chk_pulses("rs1", 1'b0, 1'b0, 1'b0);
      smp(4'b0011, 1'b0);
      chk("rs2.valid", 32'(bin_valid), 32'd1);
      chk_pulses("rs2", 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         gray_in = 4'($urandom);
         @(posedge clk);
         #1;
         chk("frz.bin", 32'(bin_out), 32'd2);
         chk("frz.pulse", {29'd0, step_up, step_down, err_multi}, 32'd0);
      end
      chk("frz.valid", 32'(bin_valid), 32'd1);
      smp(4'b0010, 1'b0);
      chk("resume.bin", 32'(bin_out), 32'd3);
      chk_pulses("resume", 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_pulses("resume+1", 1'b0, 1'b0, 1'b0);

      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      chk("clr.cnt", 32'(err_cnt), 32'd0);
      chk("clr.sticky", 32'(err_sticky), 32'd0);

      exp_cnt = 2'd0;
      for (int i = 0; i < 5; i++) begin
         if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
         smp((i % 2 == 0) ? 4'b0001 : 4'b0010, 1'b0);
         chk("sat.em", 32'(err_multi), 32'd1);
         chk("sat.cnt", 32'(err_cnt), 32'(exp_cnt));
         chk("sat.sticky", 32'(err_sticky), 32'd1);
         smp((i % 2 == 0) ? 4'b0001 : 4'b0010, 1'b0);
         smp((i % 2 == 0) ? 4'b0001 : 4'b0010, 1'b0);
         chk("sat.valid", 32'(bin_valid), 32'd1);
      end
      smp(4'b0010, 1'b1);
      chk("clrerr.em", 32'(err_multi), 32'd1);
      chk("clrerr.cnt", 32'(err_cnt), 32'd1);
      chk("clrerr.sticky", 32'(err_sticky), 32'd1);

      clk_en  = 1'b1;
      gray_in = 4'b0110;
      @(posedge clk);
      #1;
      clk_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mrst.bin", 32'(bin_out), 32'd0);
      chk("mrst.valid", 32'(bin_valid), 32'd0);
      chk("mrst.cnt", 32'(err_cnt), 32'd0);
      chk("mrst.sticky", 32'(err_sticky), 32'd0);
      chk_pulses("mrst", 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("drop.valid", 32'(bin_valid), 32'd0);
      chk("drop.bin", 32'(bin_out), 32'd0);
      chk_pulses("drop", 1'b0, 1'b0, 1'b0);
      smp(4'b0101, 1'b0);
      chk("init.bin", 32'(bin_out), 32'd6);
      chk("init.valid", 32'(bin_valid), 32'd1);
      chk_pulses("init", 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gray_decoder_tracker.md
GRAY_DECODER_TRACKER -- requirements
Module: gray_decoder_tracker

Interface
REQ-001 Parameter N, default 4, sets the width of the Gray code input and binary output in bits; legal range is 2..16.
REQ-002 Parameter ERRW, default 8, sets the width of the error counter in bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 clk_en  in  1  sample strobe; gray_in is captured only on edges where clk_en=1.
REQ-006 gray_in  in  N  Gray-coded count from an upstream gray counter.
REQ-007 err_clr  in  1  synchronous clear of err_cnt and err_sticky.
REQ-008 bin_out  out  N  binary equivalent of the last accepted Gray sample.
REQ-009 bin_valid  out  1  high while the tracker is in TRACK with a trusted bin_out.
REQ-010 step_up  out  1  one-cycle pulse: the accepted sample equals the previous sample +1 mod 2^N.
REQ-011 step_down  out  1  one-cycle pulse: the accepted sample equals the previous sample -1 mod 2^N.
REQ-012 err_multi  out  1  one-cycle pulse: the sample differs from the previous sample in more than one Gray bit.
REQ-013 err_sticky  out  1  set on any err_multi; held until err_clr or rst.
REQ-014 err_cnt  out  ERRW  saturating count of err_multi events.

Function
REQ-015 Pipeline: stage 1 registers gray_in and a valid bit (s1_v) on clk_en=1; s1_v is 0 otherwise.
REQ-016 Stage 2 processes a sample when s1_v=1; outputs change on the edge after capture, giving 2-edge latency from the clk_en edge to the outputs.
REQ-017 Conversion: bin[N-1]=g[N-1]; bin[i]=bin[i+1] XOR g[i] for i=N-2 down to 0.
REQ-018 States: INIT, TRACK, RESYNC.
REQ-019 INIT: the first processed sample loads bin_out, sets no pulse, and moves to TRACK; bin_valid=1 from that edge.
REQ-020 TRACK, Hamming distance 0 between the new and previous Gray sample: bin_out is held, no pulse, stay in TRACK.
REQ-021 TRACK, distance 1: load bin_out and pulse step_up or step_down by the mod-2^N comparison; the wrap from 2^N-1 to 0 is step_up and 0 to 2^N-1 is step_down.
REQ-022 TRACK, distance >1: pulse err_multi, set err_sticky, increment err_cnt, load bin_out with the new value, clear bin_valid, and go to RESYNC.
REQ-023 RESYNC: two consecutive processed samples with identical Gray values are required; the second one sets bin_valid=1 and returns to TRACK with no step pulse.
REQ-024 RESYNC: a processed sample differing from its predecessor restarts the two-sample count, loads bin_out, and raises no further err_multi.
REQ-025 err_cnt saturates at 2^ERRW-1; err_multi and err_sticky still assert at saturation.
REQ-026 err_clr coinciding with a new error clears the counter, then applies the new error: err_cnt=1 and err_sticky=1.
REQ-027 step_up, step_down and err_multi are mutually exclusive and are 0 on every cycle without a processed sample.
REQ-028 clk_en=0 for any number of cycles freezes all state; the comparison is always against the last processed sample.

Reset
REQ-029 rst=1 on a clock edge forces INIT, s1_v=0, bin_out=0, bin_valid=0, all pulses=0, err_sticky=0 and err_cnt=0.
REQ-030 rst has priority over clk_en and err_clr; a sample in flight in stage 1 during reset is discarded.

Structure
REQ-031 A shared package holds the state enumeration (INIT, TRACK, RESYNC) and the gray-to-binary conversion function.
REQ-032 A sub-module gray2bin_Nbits holds the purely combinational, parameterised conversion; the FSM, pipeline and counters stay in the top module.

Verification (N=4)
REQ-033 Reset, then clk_en samples 0000, 0001, 0011 -> bin_out 0, 1, 2; bin_valid=1 after the first; step_up pulses on the 2nd and 3rd samples.
REQ-034 Ascending wrap 1000 (15) -> 0000 -> step_up, bin_out=0; descending 0000 -> 1000 -> step_down, bin_out=15.
REQ-035 From 0000, apply 0011 -> err_multi pulse, err_cnt=1, bin_valid=0; then 0011, 0011 -> bin_valid=1 on the second, no step pulse.
REQ-036 Hold clk_en=0 for 10 cycles while gray_in toggles -> outputs unchanged; resume with a single-bit change -> exactly one step pulse.
REQ-037 ERRW=2: force 5 errors -> err_cnt saturates at 3; err_clr together with a 6th error -> err_cnt=1.
REQ-038 Assert rst mid-RESYNC with a sample in stage 1 -> next cycle all outputs 0, state INIT, the discarded sample produces no output.
